// File: rtl/ram_req_ctrl.sv
// Request front-end for single_port_ram: valid/ready requests in, in-order read responses out.
// Define RAM_INIT_EN to sweep the RAM to INIT_VALUE after reset before accepting traffic.
module ram_req_ctrl #(
  parameter int unsigned                  DATA_WIDTH = 8,
  parameter int unsigned                  ADDR_WIDTH = 4,
  parameter logic        [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  init_done,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  logic                  run;
  logic                  rd_inflight_q, rd_inflight_d;
  logic [DATA_WIDTH-1:0] fifo_q [2];
  logic [DATA_WIDTH-1:0] fifo_d [2];
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  push, pop, credit;
  logic [2:0]            occ;

`ifdef RAM_INIT_EN
  typedef enum logic {StInit, StRun} state_e;
  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    if (state_q == StInit) begin
      init_cnt_d = init_cnt_q + 1'b1;
      if (init_cnt_q == '1) state_d = StRun;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StInit;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  assign run       = (state_q == StRun);
  assign init_done = run;
`else
  assign run       = 1'b1;
  assign init_done = 1'b1;
`endif

  assign rsp_valid = (cnt_q != 2'd0);
  assign rsp_rdata = fifo_q[rd_ptr_q];
  assign pop       = rsp_valid & rsp_ready;
  // Dout of a read accepted last cycle is valid now.
  assign push      = rd_inflight_q;

  // Outstanding reads after this cycle's pop; rsp_ready feeds req_ready for full throughput.
  assign occ       = {1'b0, cnt_q} + {2'b00, rd_inflight_q} - {2'b00, pop};
  assign credit    = (occ < 3'd2);
  assign req_ready = rst & run & credit;

  always_comb begin
    ram_addr = '0;
    ram_din  = '0;
    ram_we   = 1'b0;
    if (rst) begin
      if (run) begin
        ram_addr = req_addr;
        ram_din  = req_wdata;
        ram_we   = req_valid & req_ready & req_we;
      end else begin
`ifdef RAM_INIT_EN
        ram_addr = init_cnt_q;
        ram_din  = INIT_VALUE;
        ram_we   = 1'b1;
`endif
      end
    end
  end

  always_comb begin
    rd_inflight_d = req_valid & req_ready & ~req_we;
    fifo_d        = fifo_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    cnt_d         = cnt_q;
    if (push) begin
      fifo_d[wr_ptr_q] = ram_dout;
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_inflight_q <= 1'b0;
      fifo_q[0]     <= '0;
      fifo_q[1]     <= '0;
      wr_ptr_q      <= 1'b0;
      rd_ptr_q      <= 1'b0;
      cnt_q         <= 2'd0;
    end else begin
      rd_inflight_q <= rd_inflight_d;
      fifo_q        <= fifo_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      cnt_q         <= cnt_d;
    end
  end

  assert property (@(posedge clk) disable iff (!rst) cnt_q <= 2'd2);

endmodule

// File: tb/tb_ram_req_ctrl.sv
// Randomized bench for ram_req_ctrl with a behavioural RAM and a transaction-level reference model.
// Follows the RAM_INIT_EN setting of the build.
module tb_ram_req_ctrl;

  localparam logic [7:0] InitV = 8'h00;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_ready, req_we;
  logic [3:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_rdata;
  logic       init_done;
  logic [3:0] ram_addr;
  logic [7:0] ram_din;
  logic       ram_we;
  logic [7:0] ram_dout;

  ram_req_ctrl #(
    .DATA_WIDTH (8),
    .ADDR_WIDTH (4),
    .INIT_VALUE (InitV)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .init_done (init_done),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_we    (ram_we),
    .ram_dout  (ram_dout)
  );

  always #5 clk = ~clk;

  // Behavioural single-port RAM with registered read.
  logic [7:0] mem [16];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int          cyc   = 0;
  logic [7:0]  model_mem [16];
  logic [7:0]  exp_q [$];
  int          acc_q [$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic set_idle();
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 4'h0;
    req_wdata = 8'h00;
    rsp_ready = 1'b0;
  endtask

  // One clock cycle of traffic; every expectation comes from the reference model.
  task automatic step(input logic v, input logic we, input logic [3:0] a, input logic [7:0] d,
                      input logic rr);
    logic exp_valid, exp_ready, pop, acc;
    @(negedge clk);
    req_valid = v;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    rsp_ready = rr;
    #1;
    exp_valid = (exp_q.size() > 0) && (cyc >= acc_q[0] + 2);
    check_val("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
    if (exp_valid) check_val("rsp_rdata", 32'(rsp_rdata), 32'(exp_q[0]));
    pop       = exp_valid && rr;
    exp_ready = (exp_q.size() - int'(pop)) < 2;
    check_val("req_ready", 32'(req_ready), 32'(exp_ready));
    acc = v && exp_ready;
    check_val("ram_we", 32'(ram_we), 32'(acc && we));
    check_val("ram_addr", 32'(ram_addr), 32'(a));
    if (pop) begin
      void'(exp_q.pop_front());
      void'(acc_q.pop_front());
    end
    if (acc) begin
      if (we) begin
        model_mem[a] = d;
      end else begin
        exp_q.push_back(model_mem[a]);
        acc_q.push_back(cyc);
      end
    end
    cyc++;
  endtask

  // Assert reset with busy-looking inputs and confirm outputs are at reset values.
  task automatic apply_reset();
    rst       = 1'b0;
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 4'hA;
    req_wdata = 8'h77;
    rsp_ready = 1'b1;
    #1;
`ifdef RAM_INIT_EN
    check_val("rst_init_done", 32'(init_done), 32'd0);
`else
    check_val("rst_init_done", 32'(init_done), 32'd1);
`endif
    check_val("rst_req_ready", 32'(req_ready), 32'd0);
    check_val("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_val("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    check_val("rst_ram_we", 32'(ram_we), 32'd0);
    check_val("rst_ram_addr", 32'(ram_addr), 32'd0);
    check_val("rst_ram_din", 32'(ram_din), 32'd0);
    exp_q.delete();
    acc_q.delete();
    repeat (2) @(negedge clk);
    set_idle();
    rst = 1'b1;
    #1;
  endtask

`ifdef RAM_INIT_EN
  // Expects to be called just after reset release; returns 1 if a reset was injected.
  task automatic sweep_check(input int abort_at, output bit aborted);
    aborted = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i == abort_at) begin
        apply_reset();
        aborted = 1'b1;
        return;
      end
      check_val("init_we", 32'(ram_we), 32'd1);
      check_val("init_addr", 32'(ram_addr), 32'(i));
      check_val("init_din", 32'(ram_din), 32'(InitV));
      check_val("init_busy", 32'({init_done, req_ready}), 32'd0);
      @(negedge clk);
      #1;
    end
    check_val("init_done", 32'(init_done), 32'd1);
    check_val("post_init_ready", 32'(req_ready), 32'd1);
    check_val("post_init_we", 32'(ram_we), 32'd0);
  endtask
`endif

  initial begin
    bit aborted;
    for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
    set_idle();
    rst = 1'b1;
    @(negedge clk);
    apply_reset();
`ifdef RAM_INIT_EN
    sweep_check(5, aborted);
    check_val("mid_reset_taken", 32'(aborted), 32'd1);
    sweep_check(-1, aborted);
    for (int i = 0; i < 16; i++) model_mem[i] = InitV;
    step(1'b1, 1'b0, 4'd7, 8'h00, 1'b1);
`else
    check_val("first_init_done", 32'(init_done), 32'd1);
    check_val("first_req_ready", 32'(req_ready), 32'd1);
    step(1'b1, 1'b1, 4'd2, 8'hFF, 1'b1);
    step(1'b1, 1'b0, 4'd2, 8'h00, 1'b1);
    for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 4'(i), 8'($urandom), 1'b1);
`endif
    // Directed ordering and backpressure sequences.
    step(1'b1, 1'b1, 4'd3, 8'hA5, 1'b1);
    step(1'b1, 1'b1, 4'd4, 8'h5C, 1'b1);
    step(1'b1, 1'b0, 4'd3, 8'h00, 1'b1);
    step(1'b1, 1'b0, 4'd4, 8'h00, 1'b1);
    repeat (3) step(1'b0, 1'b0, 4'd0, 8'h00, 1'b1);
    repeat (4) step(1'b1, 1'b0, 4'd3, 8'h00, 1'b0);
    repeat (4) step(1'b1, 1'b0, 4'd3, 8'h00, 1'b1);
    step(1'b1, 1'b1, 4'd9, 8'h3C, 1'b1);
    step(1'b1, 1'b0, 4'd9, 8'h00, 1'b1);
    repeat (3) step(1'b0, 1'b0, 4'd0, 8'h00, 1'b1);
    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 4, 4'($urandom), 8'($urandom),
           $urandom_range(0, 9) < 6);
    end
    repeat (6) step(1'b0, 1'b0, 4'd0, 8'h00, 1'b1);
    check_val("drained", 32'(rsp_valid), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ram_req_ctrl.md
Name: ram_req_ctrl

Overview:
Request front-end sitting directly upstream of single_port_ram.
- Accepts read/write requests on a valid/ready interface and drives the RAM's addr/din/we.
- Captures the RAM's registered dout and returns read data in order on a valid/ready response interface, with credit-based backpressure.
- Optionally sweeps the whole RAM to a known value after reset before accepting traffic.

Parameters:
DATA_WIDTH, 8, data word width; must match single_port_ram
ADDR_WIDTH, 4, address width; depth = 2**ADDR_WIDTH
INIT_VALUE, 0, word written to every location during init sweep (DATA_WIDTH bits)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  reset, asynchronous assert, active-low (0 = reset), synchronous release assumed by caller
req_valid  input  1  request present
req_ready  output  1  request accepted when valid&ready
req_we  input  1  1 = write, 0 = read
req_addr  input  ADDR_WIDTH  request address
req_wdata  input  DATA_WIDTH  write data
rsp_valid  output  1  read data available
rsp_ready  input  1  consumer takes rsp when valid&ready
rsp_rdata  output  DATA_WIDTH  read data, in request order
init_done  output  1  1 once RAM is usable
ram_addr  output  ADDR_WIDTH  to RAM addr
ram_din  output  DATA_WIDTH  to RAM din
ram_we  output  1  to RAM we
ram_dout  input  DATA_WIDTH  from RAM dout; valid 1 cycle after read address presented

Behaviour:
- States: INIT, RUN. rst=0 -> INIT (feature on) or RUN (feature off); init counter, in-flight flag and response FIFO cleared.
- Reset values: req_ready=0 during reset, rsp_valid=0, rsp_rdata=0, init_done=0 (feature on) / 1 (feature off), ram_we=0, ram_addr=0, ram_din=0.
- INIT: ram_we=1, ram_addr=init_cnt, ram_din=INIT_VALUE; init_cnt increments each cycle.
  - At init_cnt = 2**ADDR_WIDTH-1 the write completes, then -> RUN; init_done=1 from the next cycle.
  - Sweep takes exactly 2**ADDR_WIDTH cycles; req_ready=0 throughout.
- RAM drive in RUN (combinational from request):
  - ram_addr=req_addr, ram_din=req_wdata, ram_we = req_valid&req_ready&req_we.
  - When idle, ram_we=0 and addr/din still follow the request inputs (harmless read).
- Credit: credit = (fifo_count + rd_inflight - pop) < 2, where pop = rsp_valid&rsp_ready.
  - req_ready = RUN & credit; independent of req_we and req_valid.
  - Combinational path rsp_ready -> req_ready is intentional and gives full throughput.
- Read accept (cycle t): rd_inflight<=1. Cycle t+1: ram_dout pushed into a 2-entry FIFO.
  - rsp_valid=1 from t+2 at earliest; read latency is 2 cycles from accept to rsp_valid.
  - rsp_rdata is registered FIFO head.
- Writes produce no response; one accepted request per cycle.
- Ordering:
  - Write then read to the same address in consecutive cycles returns the new data.
  - Responses are strictly in read-accept order.
- FIFO: push and pop in the same cycle keeps count unchanged. Overflow is impossible by construction; an assertion checks fifo_count<=2.
- rsp_valid held with stable rsp_rdata until rsp_ready.
- Reset mid-operation: asynchronous clear of all state; in-flight reads and buffered responses are dropped; init sweep restarts from address 0.

Optional Feature:
RAM_INIT_EN
- Defined: INIT state and sweep present; init_done rises 2**ADDR_WIDTH cycles after reset release.
- Undefined: no INIT state or counter; RUN directly after reset; init_done tied to 1; RAM contents undefined until written.

Test Plan:
- RAM_INIT_EN on, INIT_VALUE=8'h00, release reset -> ram_we high for exactly 16 cycles at addresses 0..15, then init_done=1; read addr 4'd7 -> rsp_rdata=8'h00.
- Write 4'd3=8'hA5, then 4'd4=8'h5C, then read 3, read 4 back-to-back, rsp_ready=1 -> rsp_rdata 8'hA5 then 8'h5C on consecutive cycles, first one 2 cycles after the read-3 accept.
- rsp_ready=0, issue 3 reads of addr 3 -> first 2 accepted, req_ready=0 after that; raise rsp_ready -> 2 responses 8'hA5, then third read accepted.
- Write 4'd9=8'h3C then immediately read 4'd9 next cycle -> rsp_rdata=8'h3C.
- Assert rst=0 at init_cnt=5 -> outputs go to reset values immediately; after release, sweep restarts at address 0 and takes 16 cycles.
- RAM_INIT_EN off -> init_done=1 and req_ready=1 on the first cycle after reset release; write/read 4'd2=8'hFF returns 8'hFF.
